prng_rewind: RTL
================

PRNG_REWIND -- requirements
Module: prng_rewind

Interface
REQ-001 SHALL have parameter WIDTH, default 16, PRNG state width.
REQ-002 SHALL have parameter SHL_A, default 7, first forward left-shift amount.
REQ-003 SHALL have parameter SHR_B, default 9, second forward right-shift amount.
REQ-004 SHALL have parameter SHL_C, default 8, third forward left-shift amount.
REQ-005 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  request pulse, sampled on clk.
REQ-008 SHALL have port seed  input  WIDTH  current generator state to rewind from.
REQ-009 SHALL have port steps  input  8  number of forward steps to undo.
REQ-010 SHALL have port busy  output  1  high while a rewind is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port result  output  WIDTH  rewound state, held until next accepted start.
REQ-013 SHALL have port err  output  1  rejected-request flag (see Configuration).

Function
REQ-014 Forward step being inverted SHALL be: x^=x<<SHL_A; x^=x>>SHR_B; x^=x<<SHL_C (all truncated to WIDTH).
REQ-015 Each rewind step SHALL undo phases in order C, B, A; phase with shift s: y<=0 at entry, then ceil(WIDTH/s) cycles of y<=x_in^(y shifted by s, same direction as forward), x_in = phase input.
REQ-016 With defaults, one step SHALL take exactly 2+2+3=7 cycles.
REQ-017 FSM states SHALL be IDLE, RUN, DONE; start in IDLE latches seed, steps and goes RUN (or DONE if steps==0).
REQ-018 RUN SHALL track phase (C/B/A), iteration counter and remaining-step counter; after phase A of last step -> DONE.
REQ-019 DONE SHALL assert done for one cycle, update result, return to IDLE.
REQ-020 done SHALL occur exactly 7*steps+1 cycles after the edge sampling start (defaults); steps==0 -> result=seed after 1 cycle.
REQ-021 busy SHALL be high in RUN and DONE, low in IDLE.
REQ-022 start while busy SHALL be ignored without effect; seed/steps changes during RUN SHALL have no effect.
REQ-023 start on the DONE cycle SHALL be ignored; accepted the following cycle.

Reset
REQ-024 rst SHALL force IDLE, busy=0, done=0, err=0, result=0, all counters 0, immediately and mid-operation.
REQ-025 No done pulse SHALL follow an aborted rewind.

Configuration
REQ-026 Macro PRNG_REWIND_ZERO_CHK_EN defined: start with seed==0 in IDLE SHALL be rejected, err pulses one cycle, FSM stays IDLE, result unchanged.
REQ-027 Macro undefined: err SHALL be tied 0; seed 0 processed normally, result 0.

Structure
REQ-028 Package prng_pkg SHALL hold default shift constants, FSM state enum, phase enum and a ceil-divide function for iteration counts.
REQ-029 Single-iteration datapath (y<=x_in^(y shift s), direction select) SHALL be sub-module prng_undo_shift, instantiated once and muxed per phase.

Verification
REQ-030 seed=0x8181, steps=1 -> done after 8 cycles, result=0x0001, busy high 7+1 cycles.
REQ-031 seed=0x6021, steps=2 -> done after 15 cycles, result=0x0001.
REQ-032 seed=0x1234, steps=0 -> done next cycle, result=0x1234.
REQ-033 start during RUN with seed=0xFFFF -> ignored, original rewind result unchanged; rst asserted mid-RUN -> busy=0, no done, result=0.
REQ-034 Random seed, forward N (1..255) in reference model, rewind N -> original seed for 1000 trials.
REQ-035 With PRNG_REWIND_ZERO_CHK_EN, seed=0 start -> err one-cycle pulse, busy stays 0; without, done after 7*steps+1 cycles, result=0.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared constants, state/phase enums and iteration-count helper for the
// xorshift rewind engine.
package prng_pkg;

  localparam int unsigned DEF_SHL_A = 7;
  localparam int unsigned DEF_SHR_B = 9;
  localparam int unsigned DEF_SHL_C = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_C,
    PH_B,
    PH_A
  } phase_e;

  // Iterations needed to undo x ^= x<<s (or >>s) over n bits.
  function automatic logic [7:0] ceil_div(input int unsigned n, input int unsigned d);
    return 8'((n + d - 1) / d);
  endfunction

endpackage

// File: rtl/prng_undo_shift.sv
// One fixed-point iteration of an xorshift-phase inverse: y_o = x_i ^ (y_i shifted).
module prng_undo_shift #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [7:0]       shamt_i,
  input  logic             left_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = x_i ^ (left_i ? (y_i << shamt_i) : (y_i >> shamt_i));
  end

endmodule

// File: rtl/prng_rewind.sv
// Rewinds a 3-phase xorshift generator by 'steps' forward steps.
// Optional macro PRNG_REWIND_ZERO_CHK_EN: reject start with seed==0 and pulse err.
module prng_rewind
  import prng_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHL_A = DEF_SHL_A,
  parameter int unsigned SHR_B = DEF_SHR_B,
  parameter int unsigned SHL_C = DEF_SHL_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [7:0]       steps,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [7:0] LAST_A = ceil_div(WIDTH, SHL_A) - 8'd1;
  localparam logic [7:0] LAST_B = ceil_div(WIDTH, SHR_B) - 8'd1;
  localparam logic [7:0] LAST_C = ceil_div(WIDTH, SHL_C) - 8'd1;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [7:0]       iter_q, iter_d;
  logic [7:0]       rem_q, rem_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [7:0]       shamt;
  logic             left;
  logic [7:0]       last_iter;
  logic [WIDTH-1:0] y_new;
  logic             accept;

`ifdef PRNG_REWIND_ZERO_CHK_EN
  logic err_q;

  assign accept = start && (seed != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == ST_IDLE) && start && (seed == '0);
  end

  assign err = err_q;
`else
  assign accept = start;
  assign err    = 1'b0;
`endif

  always_comb begin
    shamt     = 8'(SHL_C);
    left      = 1'b1;
    last_iter = LAST_C;
    case (phase_q)
      PH_C: begin
        shamt     = 8'(SHL_C);
        left      = 1'b1;
        last_iter = LAST_C;
      end
      PH_B: begin
        shamt     = 8'(SHR_B);
        left      = 1'b0;
        last_iter = LAST_B;
      end
      PH_A: begin
        shamt     = 8'(SHL_A);
        left      = 1'b1;
        last_iter = LAST_A;
      end
      default: ;
    endcase
  end

  prng_undo_shift #(.WIDTH(WIDTH)) u_undo (
    .x_i    (x_q),
    .y_i    (y_q),
    .shamt_i(shamt),
    .left_i (left),
    .y_o    (y_new)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    iter_d   = iter_q;
    rem_d    = rem_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x_d     = seed;
          y_d     = '0;
          rem_d   = steps;
          phase_d = PH_C;
          iter_d  = '0;
          state_d = (steps == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (iter_q == last_iter) begin
          // Converged phase output becomes the next phase's input; y restarts at 0.
          iter_d = '0;
          y_d    = '0;
          x_d    = y_new;
          case (phase_q)
            PH_C: phase_d = PH_B;
            PH_B: phase_d = PH_A;
            default: begin
              phase_d = PH_C;
              rem_d   = rem_q - 8'd1;
              if (rem_q == 8'd1) state_d = ST_DONE;
            end
          endcase
        end else begin
          iter_d = iter_q + 8'd1;
          y_d    = y_new;
        end
      end
      ST_DONE: begin
        result_d = x_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_C;
      iter_q   <= '0;
      rem_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      iter_q   <= iter_d;
      rem_q    <= rem_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
